// File: rtl/fft_bar_overlay_if.sv
// fft_bar_overlay_if: bin write port plus video in/out bundle for the bar overlay
interface fft_bar_overlay_if #(
    parameter int MAG_W = 16
);
    logic             bin_valid;
    logic             bin_ready;
    logic [MAG_W-1:0] bin_data;
    logic             bin_last;
    logic             i_hs;
    logic             i_vs;
    logic             i_de;
    logic [23:0]      i_data;
    logic             o_hs;
    logic             o_vs;
    logic             o_de;
    logic [23:0]      o_data;

    modport master (
        output bin_valid, bin_data, bin_last, i_hs, i_vs, i_de, i_data,
        input  bin_ready, o_hs, o_vs, o_de, o_data
    );

    modport slave (
        input  bin_valid, bin_data, bin_last, i_hs, i_vs, i_de, i_data,
        output bin_ready, o_hs, o_vs, o_de, o_data
    );
endinterface

// File: rtl/fft_bar_overlay.sv
// fft_bar_overlay: draws double-buffered spectrum bars over a video stream, 3-cycle latency
module fft_bar_overlay #(
    parameter logic [11:0] H_START    = 12'd64,
    parameter logic [11:0] V_START    = 12'd400,
    parameter logic [11:0] AREA_H     = 12'd200,
    parameter int          BIN_AW     = 8,
    parameter int          BAR_W_LOG2 = 2,
    parameter int          MAG_W      = 16,
    parameter int          MAG_SHIFT  = 6,
    parameter logic [23:0] BAR_COLOR  = 24'hff8000
) (
    input logic              pclk,
    input logic              rst,
    fft_bar_overlay_if.slave bus
);
    localparam int          NUM_BINS = 1 << BIN_AW;
    localparam int          HW       = (MAG_W > 12) ? MAG_W : 12;
    localparam logic [11:0] X_END    = H_START + 12'(NUM_BINS << BAR_W_LOG2);
    localparam logic [11:0] Y_END    = V_START + AREA_H;
    localparam logic [11:0] Y_BOT    = V_START + AREA_H - 12'd1;

    logic              s1_hs, s1_vs, s1_de;
    logic [23:0]       s1_data;
    logic [11:0]       x, y, x_off;
    logic              s2_hs, s2_vs, s2_de, s2_hit;
    logic [23:0]       s2_data;
    logic [11:0]       s2_dy;
    logic [MAG_W-1:0]  mem [2*NUM_BINS];
    logic [MAG_W-1:0]  rd;
    logic              wb, db, pending;
    logic [BIN_AW-1:0] waddr, bin;
    logic [BIN_AW:0]   cnt [2];
    logic              vs_rise, de_fall, accept, close, swap, in_area, bin_ok, bar;
    logic [HW-1:0]     h_full, h_sat;

    assign db            = ~wb;
    assign vs_rise       = bus.i_vs & ~s1_vs;
    assign de_fall       = ~bus.i_de & s1_de;
    assign accept        = bus.bin_valid & ~pending;
    assign close         = accept & (bus.bin_last | (&waddr));
    assign swap          = vs_rise & pending;
    assign bus.bin_ready = ~pending;
    assign x_off         = x - H_START;
    assign bin           = BIN_AW'(x_off >> BAR_W_LOG2);
    assign bin_ok        = {1'b0, bin} < cnt[db];
    assign in_area       = s1_de && x >= H_START && x < X_END && y >= V_START && y < Y_END;

    // stage 1: register the video inputs and track the pixel position
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            {s1_hs, s1_vs, s1_de, s1_data} <= '0;
            x <= '0;
            y <= '0;
        end else begin
            {s1_hs, s1_vs, s1_de, s1_data} <= {bus.i_hs, bus.i_vs, bus.i_de, bus.i_data};
            x <= bus.i_de ? (s1_de ? x + 12'd1 : 12'd0) : 12'd0;
            y <= vs_rise ? 12'd0 : (de_fall ? y + 12'd1 : y);
        end
    end

    // bank bookkeeping: fill the write bank, close the set, swap at the next frame start
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            wb      <= 1'b0;
            pending <= 1'b0;
            waddr   <= '0;
            cnt     <= '{default: '0};
        end else if (swap) begin
            wb      <= ~wb;
            pending <= 1'b0;
        end else if (accept) begin
            waddr <= close ? '0 : waddr + 1'b1;
            if (close) begin
                cnt[wb] <= {1'b0, waddr} + 1'b1;
                pending <= 1'b1;
            end
        end
    end

    // bin RAM: write into the write bank, read the display bank for stage 2
    always_ff @(posedge pclk) begin
        if (accept) mem[{wb, waddr}] <= bus.bin_data;
        rd <= mem[{db, bin}];
    end

    // stage 2: carry video alongside the RAM read and precompute the height test
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            {s2_hs, s2_vs, s2_de, s2_data} <= '0;
            s2_hit <= 1'b0;
            s2_dy  <= '0;
        end else begin
            {s2_hs, s2_vs, s2_de, s2_data} <= {s1_hs, s1_vs, s1_de, s1_data};
            s2_hit <= in_area && bin_ok;
            s2_dy  <= Y_BOT - y;
        end
    end

    // bar height saturated at full width so large magnitudes never wrap
    always_comb begin
        h_full = HW'(rd) >> MAG_SHIFT;
        h_sat  = (h_full > HW'(AREA_H)) ? HW'(AREA_H) : h_full;
        bar    = s2_hit && (HW'(s2_dy) < h_sat);
    end

    // stage 3: output register with the bar colour mux
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            {bus.o_hs, bus.o_vs, bus.o_de, bus.o_data} <= '0;
        end else begin
            {bus.o_hs, bus.o_vs, bus.o_de} <= {s2_hs, s2_vs, s2_de};
            bus.o_data <= bar ? BAR_COLOR : s2_data;
        end
    end
endmodule
